// File: rtl/wb_queue_if.sv
// Writeback request/commit bundle between the producers (ALU, load unit), the
// writeback queue and the regfile write port.
// Latency: none (wires only). Backpressure: mem_ready/alu_ready, hold freezes drain.
// Ports: mem_*/alu_* request handshakes, hold, and the regfile write port we/wa/wd.
interface wb_queue_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_wa;
    logic [DW-1:0] alu_wd;
    logic          hold;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    // Queue side
    modport slave (
        input  mem_valid, mem_wa, mem_wd,
        input  alu_valid, alu_wa, alu_wd,
        input  hold,
        output mem_ready, alu_ready,
        output we, wa, wd
    );

    // Producer / regfile side
    modport master (
        output mem_valid, mem_wa, mem_wd,
        output alu_valid, alu_wa, alu_wd,
        output hold,
        input  mem_ready, alu_ready,
        input  we, wa, wd
    );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback queue owning the regfile write port, with pending-write lookup for decode.
// Latency: request accepted at posedge N is written to the regfile at the negedge of cycle N+1.
// Backpressure: readies drop when free slots run out (mem has priority); hold freezes the drain.
//
// Ports: clk/rst (sync, active-high); bus = request handshakes, hold and regfile write port;
//        rsa/rta lookups -> rs_pend/rt_pend (+ rs_fwd/rt_fwd); count/empty/full status.
// Optional: define WB_QUEUE_FORWARD_EN to add rs_fwd/rt_fwd (youngest matching queued data).
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    wb_queue_if.slave                    bus,
    input  logic [AW-1:0]                rsa,
    input  logic [AW-1:0]                rta,
    output logic                         rs_pend,
    output logic                         rt_pend,
`ifdef WB_QUEUE_FORWARD_EN
    output logic [DW-1:0]                rs_fwd,
    output logic [DW-1:0]                rt_fwd,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          pop;
    logic [CW:0]   free;
    logic          mem_push;
    logic          alu_push;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = !empty && !bus.hold;

    // The slot being drained this cycle is reusable by an incoming request.
    assign free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);

    assign bus.mem_ready = (free >= (CW+1)'(1));
    assign bus.alu_ready = (free >= (CW+1)'(2)) || ((free >= (CW+1)'(1)) && !bus.mem_valid);

    // Writes to $0 complete the handshake but never occupy a slot.
    assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_wa != '0);
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_wa != '0);

    assign bus.we = pop;
    assign bus.wa = empty ? '0 : q[head].wa;
    assign bus.wd = empty ? '0 : q[head].wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(mem_push) + PW'(alu_push);
            count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // Entry storage is not reset; occupancy is tracked by head/count alone.
    // When both push, mem takes the older slot.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            q[tail] <= '{wa: bus.mem_wa, wd: bus.mem_wd};
        end
        if (alu_push) begin
            q[tail + PW'(mem_push)] <= '{wa: bus.alu_wa, wd: bus.alu_wd};
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest entry.
    always_comb begin
        rs_pend = 1'b0;
        rt_pend = 1'b0;
`ifdef WB_QUEUE_FORWARD_EN
        rs_fwd  = '0;
        rt_fwd  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if ((rsa != '0) && (q[head + PW'(k)].wa == rsa)) begin
                    rs_pend = 1'b1;
`ifdef WB_QUEUE_FORWARD_EN
                    rs_fwd  = q[head + PW'(k)].wd;
`endif
                end
                if ((rta != '0) && (q[head + PW'(k)].wa == rta)) begin
                    rt_pend = 1'b1;
`ifdef WB_QUEUE_FORWARD_EN
                    rt_fwd  = q[head + PW'(k)].wd;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rsa = '0;
    logic [4:0]  rta = '0;
    logic        rs_pend, rt_pend;
`ifdef WB_QUEUE_FORWARD_EN
    logic [31:0] rs_fwd, rt_fwd;
`endif
    logic [2:0]  count;
    logic        empty, full;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf [32];
    logic [31:0] wlog [$];
    logic [31:0] expq [$];

    wb_queue_if #(.DW(32), .AW(5)) bus ();

    wb_queue #(.DEPTH(4), .DW(32), .AW(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .rsa     (rsa),
        .rta     (rta),
        .rs_pend (rs_pend),
        .rt_pend (rt_pend),
`ifdef WB_QUEUE_FORWARD_EN
        .rs_fwd  (rs_fwd),
        .rt_fwd  (rt_fwd),
`endif
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    always #5 clk = ~clk;

    // Regfile model: commits on the negedge inside the write cycle.
    always @(negedge clk) begin
        if (bus.we) begin
            rf[bus.wa] = bus.wd;
            wlog.push_back(bus.wd);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.mem_valid = v; bus.mem_wa = a; bus.mem_wd = d;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v; bus.alu_wa = a; bus.alu_wd = d;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.hold = 1'b0;
        while (!empty && n < 20) begin
            step();
            n++;
        end
        if (!empty) check({tag, "_drain_timeout"}, 32'(count), 32'd0);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_nwrites"}, 32'(wlog.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < wlog.size(); i++)
            check({tag, "_wdata"}, wlog[i], expq[i]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        drive_mem(1'b0, '0, '0);
        drive_alu(1'b0, '0, '0);
        bus.hold = 1'b0;

        // Reset and idle
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_we",        32'(bus.we),        32'd0);
        check("rst_empty",     32'(empty),         32'd1);
        check("rst_full",      32'(full),          32'd0);
        check("rst_count",     32'(count),         32'd0);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("rst_rs_pend",   32'(rs_pend),       32'd0);

        // Single ALU request on an empty queue
        drive_alu(1'b1, 5'd5, 32'h1234);
        #1;
        check("single_alu_ready", 32'(bus.alu_ready), 32'd1);
        step();
        drive_alu(1'b0, '0, '0);
        #1;
        check("single_we",    32'(bus.we), 32'd1);
        check("single_wa",    32'(bus.wa), 32'd5);
        check("single_wd",    bus.wd,      32'h1234);
        check("single_count", 32'(count),  32'd1);
        step();
        #1;
        check("single_count_after", 32'(count), 32'd0);
        check("single_we_after",    32'(bus.we), 32'd0);
        check("single_rf5",         rf[5],       32'h1234);

        // Both valid to the same register while held: ordering and lookup
        wlog.delete();
        bus.hold = 1'b1;
        drive_mem(1'b1, 5'd3, 32'hAAAA);
        drive_alu(1'b1, 5'd3, 32'hBBBB);
        #1;
        check("pair_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("pair_alu_ready", 32'(bus.alu_ready), 32'd1);
        step();
        drive_mem(1'b0, '0, '0);
        drive_alu(1'b0, '0, '0);
        rsa = 5'd3;
        rta = 5'd4;
        #1;
        check("pair_count",   32'(count),   32'd2);
        check("pair_held_we", 32'(bus.we),  32'd0);
        check("pair_rs_pend", 32'(rs_pend), 32'd1);
        check("pair_rt_pend", 32'(rt_pend), 32'd0);
`ifdef WB_QUEUE_FORWARD_EN
        check("pair_rs_fwd",  rs_fwd,       32'hBBBB);
        check("pair_rt_fwd",  rt_fwd,       32'h0);
`endif
        bus.hold = 1'b0;
        #1;
        check("pair_first_wd", bus.wd,        32'hAAAA);
        check("pair_head_pend", 32'(rs_pend), 32'd1);
        step();
        #1;
        check("pair_second_wd", bus.wd,     32'hBBBB);
        check("pair_second_wa", 32'(bus.wa), 32'd3);
        step();
        #1;
        check("pair_count_end", 32'(count),   32'd0);
        check("pair_rf3",       rf[3],        32'hBBBB);
        check("pair_pend_end",  32'(rs_pend), 32'd0);
        expq = '{32'hAAAA, 32'hBBBB};
        compare_log("pair");

        // Reset while holding three entries
        wlog.delete();
        bus.hold = 1'b1;
        drive_mem(1'b1, 5'd1, 32'h11);
        drive_alu(1'b1, 5'd2, 32'h22);
        step();
        drive_alu(1'b0, '0, '0);
        drive_mem(1'b1, 5'd3, 32'h33);
        step();
        drive_mem(1'b0, '0, '0);
        #1;
        check("midrst_count_before", 32'(count), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.hold = 1'b0;
        #1;
        check("midrst_count", 32'(count),  32'd0);
        check("midrst_we",    32'(bus.we), 32'd0);
        step(); step();
        check("midrst_no_writes", 32'(wlog.size()), 32'd0);

        // Fill to full under hold, then release with both valid
        wlog.delete();
        bus.hold = 1'b1;
        drive_mem(1'b1, 5'd1, 32'hD1);
        drive_alu(1'b1, 5'd2, 32'hD2);
        step();
        drive_mem(1'b1, 5'd3, 32'hD3);
        drive_alu(1'b1, 5'd4, 32'hD4);
        step();
        drive_mem(1'b1, 5'd6, 32'hD6);
        drive_alu(1'b1, 5'd7, 32'hD7);
        #1;
        check("full_flag",       32'(full),          32'd1);
        check("full_count",      32'(count),         32'd4);
        check("full_hold_mem_rdy", 32'(bus.mem_ready), 32'd0);
        check("full_hold_alu_rdy", 32'(bus.alu_ready), 32'd0);
        bus.hold = 1'b0;
        #1;
        check("full_rel_mem_rdy", 32'(bus.mem_ready), 32'd1);
        check("full_rel_alu_rdy", 32'(bus.alu_ready), 32'd0);
        check("full_rel_wd",      bus.wd,             32'hD1);
        step();
        drive_mem(1'b0, '0, '0);
        drive_alu(1'b0, '0, '0);
        #1;
        check("full_rel_count", 32'(count), 32'd4);
        drain("full");
        expq = '{32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD6};
        compare_log("full");

        // Register $0 request
        wlog.delete();
        drive_alu(1'b1, 5'd0, 32'hFFFF);
        rsa = 5'd0;
        #1;
        check("r0_ready", 32'(bus.alu_ready), 32'd1);
        step();
        drive_alu(1'b0, '0, '0);
        #1;
        check("r0_count",   32'(count),   32'd0);
        check("r0_we",      32'(bus.we),  32'd0);
        check("r0_rs_pend", 32'(rs_pend), 32'd0);
        step();
        check("r0_no_write", 32'(wlog.size()), 32'd0);

        // Wrap-around with random hold
        wlog.delete();
        expq.delete();
        for (int i = 0; i < 10; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            bit          acc;
            int          n;
            a   = 5'((i % 7) + 1);
            d   = 32'hC000 + 32'(i);
            acc = 1'b0;
            n   = 0;
            if (i % 2 == 0) drive_mem(1'b1, a, d);
            else            drive_alu(1'b1, a, d);
            while (!acc && n < 50) begin
                bus.hold = 1'($urandom_range(0, 1));
                #1;
                acc = (i % 2 == 0) ? bus.mem_ready : bus.alu_ready;
                if (acc) expq.push_back(d);
                step();
                check("wrap_count_cap", 32'(count > 3'd4), 32'd0);
                n++;
            end
            if (!acc) check("wrap_accept_timeout", 32'd0, 32'd1);
            drive_mem(1'b0, '0, '0);
            drive_alu(1'b0, '0, '0);
        end
        drain("wrap");
        compare_log("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
